// File: rtl/mult_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 32x32 multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_seq_pkg;

    localparam int ITER  = 32;   // shift-add iterations, one per operand bit
    localparam int CNT_W = 6;    // iteration counter width

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS_A = 3'd1,
        S_ABS_B = 3'd2,
        S_CALC  = 3'd3,
        S_FIX_L = 3'd4,
        S_FIX_H = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple adder with carry in/out, the single arithmetic unit shared by the multiplier.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b operands; i_cin carry in; o_sum 32-bit sum; o_cout carry out.
module adder_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

// File: rtl/mult_seq_32.sv
// Radix-2 shift-and-add 32x32->64 multiplier producing MIPS HI/LO for MULT/MULTU.
// Latency: DONE after start edge k+32 (unsigned), k+34 (signed, non-negative), k+36 (signed, negative).
// Backpressure: core stalls on busy; start outside IDLE is dropped, not queued.
// Ports: clk, rst_n (sync, active-low); start/signed_op/a/b request sampled in IDLE;
//        busy high outside IDLE; done one-cycle pulse; hi/lo product, held until next start.
// Build option: MULT_SEQ_SIGNED_EN enables signed_op (ABS_A/ABS_B/FIX_L/FIX_H states);
//        without it every operation is MULTU and signed_op is ignored.
module mult_seq_32
    import mult_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_mcand;
    logic [31:0]        r_mplier;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_add_a;
    logic [31:0]        w_add_b;
    logic               w_add_cin;
    logic [31:0]        w_sum;
    logic               w_cout;
    logic               w_last_iter;

`ifdef MULT_SEQ_SIGNED_EN
    logic               r_signed;
    logic               r_neg;
    logic               r_carry;
`else
    logic               w_unused_signed_op;
    assign w_unused_signed_op = signed_op;
`endif

    assign w_last_iter = (r_cnt == CNT_W'(ITER - 1));
    assign hi = r_hi;
    assign lo = r_lo;

    adder_32 u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Adder operand steering: every state that needs arithmetic borrows the one adder.
    // Two's-complement negation is ~x + 1 via cin; FIX_H folds in the carry from FIX_L.
    always_comb begin
        w_add_a   = r_hi;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            S_CALC:  w_add_b = r_mplier[0] ? r_mcand : '0;
`ifdef MULT_SEQ_SIGNED_EN
            S_ABS_A: begin w_add_a = ~r_mcand;  w_add_cin = 1'b1;    end
            S_ABS_B: begin w_add_a = ~r_mplier; w_add_cin = 1'b1;    end
            S_FIX_L: begin w_add_a = ~r_lo;     w_add_cin = 1'b1;    end
            S_FIX_H: begin w_add_a = ~r_hi;     w_add_cin = r_carry; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MULT_SEQ_SIGNED_EN
                    w_state_nxt = signed_op ? S_ABS_A : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
`ifdef MULT_SEQ_SIGNED_EN
            S_ABS_A: w_state_nxt = S_ABS_B;
            S_ABS_B: w_state_nxt = S_CALC;
            S_CALC:  if (w_last_iter) w_state_nxt = (r_signed && r_neg) ? S_FIX_L : S_DONE;
            S_FIX_L: w_state_nxt = S_FIX_H;
            S_FIX_H: w_state_nxt = S_DONE;
`else
            S_CALC:  if (w_last_iter) w_state_nxt = S_DONE;
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_hi     <= '0;
                        r_lo     <= '0;
                        r_cnt    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
                        r_signed <= signed_op;
                        r_neg    <= a[31] ^ b[31];
`endif
                    end
                end
`ifdef MULT_SEQ_SIGNED_EN
                // 0x80000000 negates to itself, which is the correct unsigned magnitude.
                S_ABS_A: if (r_mcand[31])  r_mcand  <= w_sum;
                S_ABS_B: if (r_mplier[31]) r_mplier <= w_sum;
                S_FIX_L: begin
                    r_lo    <= w_sum;
                    r_carry <= w_cout;
                end
                S_FIX_H: r_hi <= w_sum;
`endif
                S_CALC: begin
                    // {cout, sum, lo} >> 1: low product bits stream into lo from the top.
                    r_hi     <= {w_cout, w_sum[31:1]};
                    r_lo     <= {w_sum[0], r_lo[31:1]};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_32.sv
module tb_mult_seq_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    mult_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_timeout", {63'd0, done}, 64'd1);
    endtask

    // lat = edges from the start edge to the edge after which done is visible.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
        exp_t e;
        wait_idle();
        a         = ia;
        b         = ib;
        signed_op = is;
        start     = 1'b1;
        e.hi  = eh;
        e.lo  = el;
        e.due = cyc + 1 + lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b1;
        signed_op = 1'b0;
        a         = 32'd3;
        b         = 32'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        start = 1'b0;

        do_op(32'd3, 32'd5, 1'b0, 32'h0, 32'h0000000F, 32);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 32);
        do_op(32'h12345678, 32'h00010000, 1'b0, 32'h00001234, 32'h56780000, 32);
`ifdef MULT_SEQ_SIGNED_EN
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h00000001, 34);
        do_op(32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000, 36);
        do_op(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 34);
        do_op(32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 36);
        do_op(32'hFFFFFFFB, 32'h00000000, 1'b1, 32'h0, 32'h0, 36);
`else
        // signed_op is ignored: treated as MULTU with unsigned timing
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 32);
        do_op(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 32);
`endif

        // Ignored start during CALC and DONE; operands change after the start cycle.
        do_op(32'd7, 32'd9, 1'b0, 32'h0, 32'd63, 32);
        repeat (10) @(negedge clk);
        a = 32'hFFFF0000; b = 32'h0000FFFF; signed_op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("no_extra_done", 64'(exp_q.size()), 64'd0);
        chk("idle_after_ignore", {63'd0, busy}, 64'd0);

        // Abort via reset part-way through CALC.
        wait_idle();
        a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_pre_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Back-to-back: new start in the first IDLE cycle, previous result held until then.
        do_op(32'd6, 32'd7, 1'b0, 32'h0, 32'd42, 32);
        wait_done();
        @(negedge clk);
        chk("hold_busy", {63'd0, busy}, 64'd0);
        chk("hold_lo", {32'd0, lo}, 64'd42);
        do_op(32'h00001234, 32'h0, 1'b0, 32'h0, 32'h0, 32);
        chk("b2b_accepted", {63'd0, busy}, 64'd1);
        chk("b2b_cleared_lo", {32'd0, lo}, 64'd0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
